// File: rtl/ibex_pkg.sv
// ---------------------------------------------------------------------------
// ibex_pkg : shared types and constants for the writeback stage.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ibex_pkg;

   localparam int unsigned RF_ADDR_W = 5;

   typedef enum logic [1:0] {
      WB_INSTR_LOAD  = 2'd0,
      WB_INSTR_STORE = 2'd1,
      WB_INSTR_OTHER = 2'd2
   } wb_instr_type_e;

endpackage

`default_nettype wire

// File: rtl/ibex_wb_retire_cnt.sv
// ---------------------------------------------------------------------------
// ibex_wb_retire_cnt : wrapping retired-instruction counter.        Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ibex_wb_retire_cnt #(
   parameter int unsigned RetCntWidth = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   incr_i,
   output logic [RetCntWidth-1:0] cnt_o
);

   logic [RetCntWidth-1:0] cnt_q;
   logic [RetCntWidth-1:0] cnt_d;

   // Natural modulo-2^N wrap from all-ones back to zero.
   always_comb begin
      cnt_d = cnt_q;
      if (incr_i) begin
         cnt_d = cnt_q + {{(RetCntWidth-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/ibex_wb_stage.sv
// ---------------------------------------------------------------------------
// ibex_wb_stage : one-entry writeback stage with LSU data merge.    Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ibex_wb_stage
   import ibex_pkg::*;
#(
   parameter int unsigned RetCntWidth = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   en_wb_i,
   input  wb_instr_type_e         instr_type_wb_i,
   input  logic [RF_ADDR_W-1:0]   rf_waddr_id_i,
   input  logic [31:0]            rf_wdata_id_i,
   input  logic                   rf_we_id_i,
   input  logic                   lsu_resp_valid_i,
   input  logic                   lsu_resp_err_i,
   input  logic [31:0]            lsu_rdata_i,
   output logic                   ready_wb_o,
   output logic                   rf_we_wb_o,
   output logic [RF_ADDR_W-1:0]   rf_waddr_wb_o,
   output logic [31:0]            rf_wdata_wb_o,
   output logic [31:0]            rf_wdata_fwd_o,
   output logic                   outstanding_load_o,
   output logic                   instr_done_wb_o,
   output logic                   lsu_err_wb_o,
   output logic [RetCntWidth-1:0] instr_ret_cnt_o
);

   logic                 wb_valid_q;
   logic                 wb_valid_d;
   wb_instr_type_e       type_q;
   logic [RF_ADDR_W-1:0] waddr_q;
   logic [31:0]          wdata_q;
   logic                 we_q;

   logic is_load;
   logic is_load_or_store;
   logic wb_done;
   logic accept;

   assign is_load          = (type_q == WB_INSTR_LOAD);
   assign is_load_or_store = is_load || (type_q == WB_INSTR_STORE);

   // Memory instructions wait for the LSU; everything else completes at once.
   assign wb_done = wb_valid_q && (is_load_or_store ? lsu_resp_valid_i : 1'b1);
   assign ready_wb_o = !wb_valid_q || wb_done;
   assign accept     = en_wb_i && ready_wb_o;

   always_comb begin
      wb_valid_d = wb_valid_q;
      if (accept) begin
         wb_valid_d = 1'b1;
      end else if (wb_done) begin
         wb_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wb_valid_q <= 1'b0;
         type_q     <= WB_INSTR_LOAD;
         waddr_q    <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
      end else begin
         wb_valid_q <= wb_valid_d;
         if (accept) begin
            type_q  <= instr_type_wb_i;
            waddr_q <= rf_waddr_id_i;
            wdata_q <= rf_wdata_id_i;
            we_q    <= rf_we_id_i;
         end
      end
   end

   // A bus error on a memory access suppresses the register write.
   assign rf_we_wb_o         = wb_done && we_q && !(is_load_or_store && lsu_resp_err_i);
   assign rf_waddr_wb_o      = waddr_q;
   assign rf_wdata_wb_o      = is_load ? lsu_rdata_i : wdata_q;
   assign rf_wdata_fwd_o     = wdata_q;
   assign outstanding_load_o = wb_valid_q && is_load && !lsu_resp_valid_i;
   assign instr_done_wb_o    = wb_done;
   assign lsu_err_wb_o       = wb_done && is_load_or_store && lsu_resp_err_i;

   ibex_wb_retire_cnt #(
      .RetCntWidth(RetCntWidth)
   ) u_retire_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .incr_i(wb_done),
      .cnt_o (instr_ret_cnt_o)
   );

`ifndef SYNTHESIS
   a_no_accept_when_busy : assert property (
      @(posedge clk_i) disable iff (rst_i) en_wb_i |-> ready_wb_o);
   a_resp_needs_mem_instr : assert property (
      @(posedge clk_i) disable iff (rst_i)
      lsu_resp_valid_i |-> (wb_valid_q && is_load_or_store));
`endif

endmodule

`default_nettype wire

// File: tb/tb_ibex_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_ibex_wb_stage : directed and random checks of the writeback stage. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ibex_wb_stage;
   import ibex_pkg::*;

   logic           clk_i = 1'b0;
   logic           rst_i;
   logic           en_wb_i;
   wb_instr_type_e instr_type_wb_i;
   logic [4:0]     rf_waddr_id_i;
   logic [31:0]    rf_wdata_id_i;
   logic           rf_we_id_i;
   logic           lsu_resp_valid_i;
   logic           lsu_resp_err_i;
   logic [31:0]    lsu_rdata_i;
   logic           ready_wb_o;
   logic           rf_we_wb_o;
   logic [4:0]     rf_waddr_wb_o;
   logic [31:0]    rf_wdata_wb_o;
   logic [31:0]    rf_wdata_fwd_o;
   logic           outstanding_load_o;
   logic           instr_done_wb_o;
   logic           lsu_err_wb_o;
   logic [31:0]    instr_ret_cnt_o;

   int n_checks = 0;
   int n_errors = 0;

   ibex_wb_stage #(.RetCntWidth(32)) dut (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .en_wb_i           (en_wb_i),
      .instr_type_wb_i   (instr_type_wb_i),
      .rf_waddr_id_i     (rf_waddr_id_i),
      .rf_wdata_id_i     (rf_wdata_id_i),
      .rf_we_id_i        (rf_we_id_i),
      .lsu_resp_valid_i  (lsu_resp_valid_i),
      .lsu_resp_err_i    (lsu_resp_err_i),
      .lsu_rdata_i       (lsu_rdata_i),
      .ready_wb_o        (ready_wb_o),
      .rf_we_wb_o        (rf_we_wb_o),
      .rf_waddr_wb_o     (rf_waddr_wb_o),
      .rf_wdata_wb_o     (rf_wdata_wb_o),
      .rf_wdata_fwd_o    (rf_wdata_fwd_o),
      .outstanding_load_o(outstanding_load_o),
      .instr_done_wb_o   (instr_done_wb_o),
      .lsu_err_wb_o      (lsu_err_wb_o),
      .instr_ret_cnt_o   (instr_ret_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // Reference model: an occupancy flag plus the last accepted instruction.
   typedef struct {
      wb_instr_type_e ty;
      logic [4:0]     wa;
      logic [31:0]    wd;
      logic           we;
   } instr_t;

   bit          m_held;
   instr_t      m_last;
   logic [31:0] m_cnt;

   task automatic model_reset();
      m_held    = 0;
      m_last.ty = WB_INSTR_LOAD;
      m_last.wa = '0;
      m_last.wd = '0;
      m_last.we = 1'b0;
      m_cnt     = '0;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: drive at negedge, check outputs mid-cycle, advance model at posedge.
   task automatic step(input logic en, input wb_instr_type_e ty, input logic [4:0] wa,
                       input logic [31:0] wd, input logic we, input logic rv,
                       input logic re, input logic [31:0] rd);
      bit is_mem, done, exp_we, rdy;
      logic [31:0] exp_wd;
      @(negedge clk_i);
      en_wb_i = en; instr_type_wb_i = ty; rf_waddr_id_i = wa; rf_wdata_id_i = wd;
      rf_we_id_i = we; lsu_resp_valid_i = rv; lsu_resp_err_i = re; lsu_rdata_i = rd;
      #1;
      is_mem = m_held && (m_last.ty != WB_INSTR_OTHER);
      done   = m_held && (!is_mem || rv);
      rdy    = !m_held || done;
      exp_we = done && m_last.we && !(is_mem && re);
      exp_wd = (m_last.ty == WB_INSTR_LOAD) ? rd : m_last.wd;
      check("ready", 32'(ready_wb_o), 32'(rdy));
      check("done", 32'(instr_done_wb_o), 32'(done));
      check("rf_we", 32'(rf_we_wb_o), 32'(exp_we));
      check("lsu_err", 32'(lsu_err_wb_o), 32'(done && is_mem && re));
      check("outstanding", 32'(outstanding_load_o),
            32'(m_held && m_last.ty == WB_INSTR_LOAD && !rv));
      check("cnt", instr_ret_cnt_o, m_cnt);
      check("fwd", rf_wdata_fwd_o, m_last.wd);
      if (exp_we) begin
         check("waddr", 32'(rf_waddr_wb_o), 32'(m_last.wa));
         check("wdata", rf_wdata_wb_o, exp_wd);
      end
      @(posedge clk_i);
      if (done) begin
         m_cnt  = m_cnt + 1;
         m_held = 0;
      end
      if (en && rdy) begin
         m_held    = 1;
         m_last.ty = ty; m_last.wa = wa; m_last.wd = wd; m_last.we = we;
      end
   endtask

   task automatic idle(input logic rv, input logic re, input logic [31:0] rd);
      step(1'b0, WB_INSTR_OTHER, 5'd0, 32'd0, 1'b0, rv, re, rd);
   endtask

   initial begin
      rst_i = 1'b1; en_wb_i = 1'b0; instr_type_wb_i = WB_INSTR_OTHER;
      rf_waddr_id_i = '0; rf_wdata_id_i = '0; rf_we_id_i = 1'b0;
      lsu_resp_valid_i = 1'b0; lsu_resp_err_i = 1'b0; lsu_rdata_i = '0;
      model_reset();
      repeat (2) @(negedge clk_i);
      check("rst_ready", 32'(ready_wb_o), 32'd1);
      check("rst_rf_we", 32'(rf_we_wb_o), 32'd0);
      check("rst_cnt", instr_ret_cnt_o, 32'd0);
      check("rst_fwd", rf_wdata_fwd_o, 32'd0);
      rst_i = 1'b0;

      // Idle, then a single OTHER instruction.
      idle(1'b0, 1'b0, 32'd0);
      step(1'b1, WB_INSTR_OTHER, 5'd5, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 32'd0);
      idle(1'b0, 1'b0, 32'd0);
      #1 check("t2_cnt", instr_ret_cnt_o, 32'd1);

      // Load held for three cycles, then answered.
      step(1'b1, WB_INSTR_LOAD, 5'd7, 32'h0000_1000, 1'b1, 1'b0, 1'b0, 32'd0);
      repeat (3) idle(1'b0, 1'b0, 32'hFFFF_FFFF);
      idle(1'b1, 1'b0, 32'h1234_5678);

      // Load answered with a bus error.
      step(1'b1, WB_INSTR_LOAD, 5'd9, 32'h0000_2000, 1'b1, 1'b0, 1'b0, 32'd0);
      idle(1'b1, 1'b1, 32'hBAD0_BAD0);
      #1 check("t4_cnt", instr_ret_cnt_o, 32'd3);

      // Four back-to-back OTHER instructions.
      for (int i = 0; i < 4; i++) begin
         step(1'b1, WB_INSTR_OTHER, 5'(10 + i), 32'hA000_0000 + 32'(i), 1'b1, 1'b0, 1'b0, 32'd0);
      end
      idle(1'b0, 1'b0, 32'd0);
      #1 check("t5_cnt", instr_ret_cnt_o, 32'd7);

      // Randomised traffic obeying the handshake rules.
      for (int i = 0; i < 400; i++) begin
         bit mem_held, rdy_now, en, rv;
         wb_instr_type_e ty;
         mem_held = m_held && (m_last.ty != WB_INSTR_OTHER);
         rv       = mem_held && ($urandom_range(0, 2) != 0);
         rdy_now  = !m_held || !mem_held || rv;
         en       = rdy_now && ($urandom_range(0, 3) != 0);
         ty       = wb_instr_type_e'($urandom_range(0, 2));
         step(en, ty, 5'($urandom), $urandom,
              (ty == WB_INSTR_STORE) ? 1'b0 : 1'($urandom),
              rv, rv && ($urandom_range(0, 4) == 0), $urandom);
      end
      while (m_held) begin
         idle(m_last.ty != WB_INSTR_OTHER, 1'b0, $urandom);
      end

      // Reset arriving while a load is outstanding.
      step(1'b1, WB_INSTR_LOAD, 5'd3, 32'h5555_AAAA, 1'b1, 1'b0, 1'b0, 32'd0);
      @(negedge clk_i);
      en_wb_i = 1'b0; lsu_resp_valid_i = 1'b0; lsu_resp_err_i = 1'b0;
      #1 check("pre_rst_outstanding", 32'(outstanding_load_o), 32'd1);
      rst_i = 1'b1;
      #1;
      check("mid_rst_ready", 32'(ready_wb_o), 32'd1);
      check("mid_rst_rf_we", 32'(rf_we_wb_o), 32'd0);
      check("mid_rst_done", 32'(instr_done_wb_o), 32'd0);
      check("mid_rst_cnt", instr_ret_cnt_o, 32'd0);
      check("mid_rst_outstanding", 32'(outstanding_load_o), 32'd0);
      model_reset();
      @(negedge clk_i);
      rst_i = 1'b0;
      idle(1'b0, 1'b0, 32'd0);
      step(1'b1, WB_INSTR_OTHER, 5'd1, 32'h0BAD_F00D, 1'b1, 1'b0, 1'b0, 32'd0);
      idle(1'b0, 1'b0, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
